// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// axi_read_arbiter: shares one AXI read master between the IC and DC caches.
// Optional macro AXI_READ_ARB_ROUND_ROBIN_EN selects round-robin (else DC wins).
// Revision: 1.0
// ============================================================================
module axi_read_arbiter #(
    parameter int addr_width = 64,
    parameter int data_width = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_arvalid,
    input  logic [addr_width-1:0] ic_araddr,
    input  logic [7:0]            ic_arlen,
    input  logic [2:0]            ic_arsize,
    input  logic [1:0]            ic_arburst,
    output logic                  ic_arready,
    output logic                  ic_rvalid,
    output logic                  ic_rlast,
    output logic [data_width-1:0] ic_rdata,
    input  logic                  ic_rready,
    input  logic                  dc_arvalid,
    input  logic [addr_width-1:0] dc_araddr,
    input  logic [7:0]            dc_arlen,
    input  logic [2:0]            dc_arsize,
    input  logic [1:0]            dc_arburst,
    output logic                  dc_arready,
    output logic                  dc_rvalid,
    output logic                  dc_rlast,
    output logic [data_width-1:0] dc_rdata,
    input  logic                  dc_rready,
    output logic                  m_axi_arvalid,
    output logic [addr_width-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rlast,
    input  logic [data_width-1:0] m_axi_rdata,
    output logic                  m_axi_rready,
    input  logic                  snoop_stall,
    output logic                  instruction_cache_reading,
    output logic                  data_cache_reading,
    output logic                  rlast_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner_dc;
    logic [addr_width-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [8:0]            r_beat;
    logic                  r_rlast_error;
    logic                  w_grant;
    logic                  w_pick_dc;
    logic                  w_beat;
    logic                  w_len_hit;

`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
    logic r_last_dc;
    // On a tie the requester that did not win last time is chosen.
    assign w_pick_dc = dc_arvalid & (~ic_arvalid | ~r_last_dc);
`else
    assign w_pick_dc = dc_arvalid;
`endif

    assign w_len_hit = (r_beat == {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_beat       = 1'b0;
        ic_arready   = 1'b0;
        dc_arready   = 1'b0;
        ic_rvalid    = 1'b0;
        ic_rlast     = 1'b0;
        ic_rdata     = '0;
        dc_rvalid    = 1'b0;
        dc_rlast     = 1'b0;
        dc_rdata     = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready = 1'b0;
        case (r_state)
            IDLE: begin
                if (!snoop_stall && (ic_arvalid || dc_arvalid)) begin
                    w_grant    = 1'b1;
                    ic_arready = ~w_pick_dc;
                    dc_arready = w_pick_dc;
                    w_next     = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (r_owner_dc) begin
                    dc_rvalid    = m_axi_rvalid;
                    dc_rlast     = m_axi_rlast;
                    dc_rdata     = m_axi_rdata;
                    m_axi_rready = dc_rready;
                end else begin
                    ic_rvalid    = m_axi_rvalid;
                    ic_rlast     = m_axi_rlast;
                    ic_rdata     = m_axi_rdata;
                    m_axi_rready = ic_rready;
                end
                w_beat = m_axi_rvalid & m_axi_rready;
                if (w_beat && m_axi_rlast) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_dc    <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_beat        <= '0;
            r_rlast_error <= 1'b0;
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
            r_last_dc     <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                r_owner_dc <= w_pick_dc;
                r_addr     <= w_pick_dc ? dc_araddr  : ic_araddr;
                r_len      <= w_pick_dc ? dc_arlen   : ic_arlen;
                r_size     <= w_pick_dc ? dc_arsize  : ic_arsize;
                r_burst    <= w_pick_dc ? dc_arburst : ic_arburst;
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
                r_last_dc  <= w_pick_dc;
`endif
            end
            if (r_state == ADDR && m_axi_arready) begin
                r_beat <= '0;
            end
            if (w_beat) begin
                r_beat <= r_beat + 9'd1;
                // Error when rlast and the final-index beat disagree.
                if (m_axi_rlast != w_len_hit) begin
                    r_rlast_error <= 1'b1;
                end
            end
        end
    end

    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = r_size;
    assign m_axi_arburst = r_burst;
    assign rlast_error   = r_rlast_error;
    assign instruction_cache_reading = (r_state != IDLE) & ~r_owner_dc;
    assign data_cache_reading        = (r_state != IDLE) &  r_owner_dc;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter.
// Revision: 1.0
// ============================================================================
module tb_axi_read_arbiter;

    logic        clk;
    logic        reset;
    logic        ic_arvalid, dc_arvalid;
    logic [63:0] ic_araddr, dc_araddr;
    logic [7:0]  ic_arlen, dc_arlen;
    logic [2:0]  ic_arsize, dc_arsize;
    logic [1:0]  ic_arburst, dc_arburst;
    logic        ic_arready, dc_arready;
    logic        ic_rvalid, dc_rvalid;
    logic        ic_rlast, dc_rlast;
    logic [63:0] ic_rdata, dc_rdata;
    logic        ic_rready, dc_rready;
    logic        m_axi_arvalid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arready;
    logic        m_axi_rvalid, m_axi_rlast;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rready;
    logic        snoop_stall;
    logic        instruction_cache_reading, data_cache_reading;
    logic        rlast_error;

    int n_cmp = 0;
    int n_err = 0;

`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
    localparam bit c_second_dc = 1'b0;
`else
    localparam bit c_second_dc = 1'b1;
`endif

    axi_read_arbiter #(.addr_width(64), .data_width(64)) dut (
        .clk(clk), .reset(reset),
        .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
        .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_arready(ic_arready),
        .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rdata(ic_rdata),
        .ic_rready(ic_rready),
        .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
        .dc_arsize(dc_arsize), .dc_arburst(dc_arburst), .dc_arready(dc_arready),
        .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast), .dc_rdata(dc_rdata),
        .dc_rready(dc_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rdata(m_axi_rdata), .m_axi_rready(m_axi_rready),
        .snoop_stall(snoop_stall),
        .instruction_cache_reading(instruction_cache_reading),
        .data_cache_reading(data_cache_reading),
        .rlast_error(rlast_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [215:0] w_all_out = {ic_arready, dc_arready, ic_rvalid, dc_rvalid,
                              ic_rlast, dc_rlast, ic_rdata, dc_rdata,
                              m_axi_arvalid, m_axi_araddr, m_axi_arlen,
                              m_axi_arsize, m_axi_arburst, m_axi_rready,
                              instruction_cache_reading, data_cache_reading,
                              rlast_error};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Drives R beats from the bus; rlast on index last_idx.
    task automatic bus_burst(input int nbeats, input int last_idx);
        for (int i = 0; i < nbeats; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'h100 + 64'(i);
            m_axi_rlast  = (i == last_idx);
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    // Requests, lets the grant and AR handshake happen, ends in DATA.
    task automatic grant_to_data(input bit dc, input logic [63:0] addr, input logic [7:0] len);
        if (dc) begin
            dc_arvalid = 1'b1; dc_araddr = addr; dc_arlen = len;
        end else begin
            ic_arvalid = 1'b1; ic_araddr = addr; ic_arlen = len;
        end
        step();
        ic_arvalid = 1'b0;
        dc_arvalid = 1'b0;
        step();
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (w_all_out !== 216'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", w_all_out);
        end
        step();
    endtask

    task automatic test_single_ic;
        ic_rready = 1'b1; dc_rready = 1'b0; m_axi_arready = 1'b0;
        ic_arvalid = 1'b1; ic_araddr = 64'h1000; ic_arlen = 8'd7;
        ic_arsize = 3'd3; ic_arburst = 2'd1;
        @(negedge clk);
        n_cmp++;
        if ({ic_arready, dc_arready, m_axi_arvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL ic_grant: got %b want 100", {ic_arready, dc_arready, m_axi_arvalid});
        end
        step();
        ic_arvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen, ic_arready, instruction_cache_reading}
            !== {1'b1, 64'h1000, 8'd7, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ic_ar: got v=%b a=%h l=%0d rdy=%b rd=%b want v=1 a=1000 l=7 rdy=0 rd=1",
                     m_axi_arvalid, m_axi_araddr, m_axi_arlen, ic_arready, instruction_cache_reading);
        end
        step();
        m_axi_arready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_axi_arvalid, m_axi_arsize, m_axi_arburst} !== {1'b1, 3'd3, 2'd1}) begin
            n_err++;
            $display("FAIL ic_ar_hold: got v=%b s=%0d b=%0d want v=1 s=3 b=1",
                     m_axi_arvalid, m_axi_arsize, m_axi_arburst);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'hA500 + 64'(i);
            m_axi_rlast  = (i == 7);
            @(negedge clk);
            n_cmp++;
            if ({ic_rvalid, ic_rlast, ic_rdata} !== {1'b1, (i == 7), 64'hA500 + 64'(i)}) begin
                n_err++;
                $display("FAIL ic_beat%0d: got v=%b l=%b d=%h want v=1 l=%0d d=%h",
                         i, ic_rvalid, ic_rlast, ic_rdata, (i == 7), 64'hA500 + 64'(i));
            end
            n_cmp++;
            if ({dc_rvalid, dc_rlast, dc_rdata, m_axi_rready, instruction_cache_reading}
                !== {1'b0, 1'b0, 64'd0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL dc_quiet%0d: got v=%b l=%b d=%h rr=%b rd=%b want 0 0 0 1 1",
                         i, dc_rvalid, dc_rlast, dc_rdata, m_axi_rready, instruction_cache_reading);
            end
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({instruction_cache_reading, rlast_error, m_axi_arvalid} !== 3'b000) begin
            n_err++;
            $display("FAIL ic_done: got %b want 000",
                     {instruction_cache_reading, rlast_error, m_axi_arvalid});
        end
        step();
    endtask

    task automatic test_tie_back_to_back;
        ic_rready = 1'b1; dc_rready = 1'b1;
        ic_arvalid = 1'b1; ic_araddr = 64'h2000; ic_arlen = 8'd0;
        dc_arvalid = 1'b1; dc_araddr = 64'h3000; dc_arlen = 8'd0;
        @(negedge clk);
        n_cmp++;
        if ({ic_arready, dc_arready} !== 2'b01) begin
            n_err++;
            $display("FAIL tie1_grant: got %b want 01", {ic_arready, dc_arready});
        end
        step();
        dc_arvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_axi_araddr, instruction_cache_reading, data_cache_reading} !== {64'h3000, 2'b01}) begin
            n_err++;
            $display("FAIL tie1_ar: got a=%h flags=%b%b want a=3000 flags=01",
                     m_axi_araddr, instruction_cache_reading, data_cache_reading);
        end
        step();
        bus_burst(1, 0);
        dc_arvalid = 1'b1; dc_araddr = 64'h3100;
        @(negedge clk);
        n_cmp++;
        if ({ic_arready, dc_arready} !== {~c_second_dc, c_second_dc}) begin
            n_err++;
            $display("FAIL tie2_grant: got %b want %b", {ic_arready, dc_arready},
                     {~c_second_dc, c_second_dc});
        end
        step();
        if (c_second_dc) dc_arvalid = 1'b0; else ic_arvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_axi_araddr, instruction_cache_reading, data_cache_reading}
            !== {(c_second_dc ? 64'h3100 : 64'h2000), ~c_second_dc, c_second_dc}) begin
            n_err++;
            $display("FAIL tie2_ar: got a=%h flags=%b%b", m_axi_araddr,
                     instruction_cache_reading, data_cache_reading);
        end
        step();
        bus_burst(1, 0);
        @(negedge clk);
        n_cmp++;
        if ({ic_arready, dc_arready} !== {c_second_dc, ~c_second_dc}) begin
            n_err++;
            $display("FAIL tie3_grant: got %b want %b", {ic_arready, dc_arready},
                     {c_second_dc, ~c_second_dc});
        end
        step();
        ic_arvalid = 1'b0; dc_arvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ((instruction_cache_reading & data_cache_reading) !== 1'b0 ||
            m_axi_araddr !== (c_second_dc ? 64'h2000 : 64'h3100)) begin
            n_err++;
            $display("FAIL tie3_ar: got a=%h flags=%b%b", m_axi_araddr,
                     instruction_cache_reading, data_cache_reading);
        end
        step();
        bus_burst(1, 0);
    endtask

    task automatic test_snoop_stall;
        snoop_stall = 1'b1;
        dc_arvalid = 1'b1; dc_araddr = 64'h4000; dc_arlen = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dc_arready, ic_arready, m_axi_arvalid} !== 3'b000) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %b want 000", i,
                         {dc_arready, ic_arready, m_axi_arvalid});
            end
            step();
        end
        snoop_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dc_arready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got dc_arready=%b want 1", dc_arready);
        end
        step();
        dc_arvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h4000}) begin
            n_err++;
            $display("FAIL stall_ar: got v=%b a=%h want v=1 a=4000", m_axi_arvalid, m_axi_araddr);
        end
        step();
        bus_burst(1, 0);
    endtask

    task automatic test_stall_mid_data;
        dc_arvalid = 1'b1; dc_araddr = 64'h5000; dc_arlen = 8'd3;
        step();
        dc_arvalid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) snoop_stall = 1'b1;
            if (i == 2) begin
                dc_arvalid = 1'b1; dc_araddr = 64'h5100; dc_arlen = 8'd0;
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'h500 + 64'(i);
            m_axi_rlast  = (i == 3);
            @(negedge clk);
            n_cmp++;
            if ({dc_rvalid, dc_rlast, dc_rdata, dc_arready} !== {1'b1, (i == 3), 64'h500 + 64'(i), 1'b0}) begin
                n_err++;
                $display("FAIL midstall_beat%0d: got v=%b l=%b d=%h rdy=%b", i,
                         dc_rvalid, dc_rlast, dc_rdata, dc_arready);
            end
            step();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dc_arready, m_axi_arvalid, data_cache_reading, rlast_error} !== 4'b0000) begin
                n_err++;
                $display("FAIL midstall_block%0d: got %b want 0000", i,
                         {dc_arready, m_axi_arvalid, data_cache_reading, rlast_error});
            end
            step();
        end
        snoop_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dc_arready !== 1'b1) begin
            n_err++;
            $display("FAIL midstall_release: got %b want 1", dc_arready);
        end
        step();
        dc_arvalid = 1'b0;
        step();
        bus_burst(1, 0);
    endtask

    task automatic test_early_rlast;
        grant_to_data(1'b1, 64'h6000, 8'd3);
        bus_burst(2, 1);
        @(negedge clk);
        n_cmp++;
        if ({rlast_error, data_cache_reading, m_axi_rready} !== 3'b100) begin
            n_err++;
            $display("FAIL early_rlast: got err/rd/rr=%b want 100",
                     {rlast_error, data_cache_reading, m_axi_rready});
        end
        step();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (rlast_error !== 1'b0) begin
            n_err++;
            $display("FAIL early_clear: got %b want 0", rlast_error);
        end
        step();
    endtask

    task automatic test_missing_rlast;
        grant_to_data(1'b1, 64'h7000, 8'd3);
        bus_burst(4, 99);
        @(negedge clk);
        n_cmp++;
        if ({rlast_error, data_cache_reading} !== 2'b11) begin
            n_err++;
            $display("FAIL missing_rlast: got err/rd=%b want 11", {rlast_error, data_cache_reading});
        end
        step();
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'h777;
        @(negedge clk);
        n_cmp++;
        if ({dc_rvalid, dc_rlast, dc_rdata} !== {2'b11, 64'h777}) begin
            n_err++;
            $display("FAIL late_rlast_beat: got v=%b l=%b d=%h want 1 1 777",
                     dc_rvalid, dc_rlast, dc_rdata);
        end
        step();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rlast_error, data_cache_reading} !== 2'b10) begin
            n_err++;
            $display("FAIL late_rlast_done: got err/rd=%b want 10", {rlast_error, data_cache_reading});
        end
        step();
    endtask

    task automatic test_reset_mid_burst;
        grant_to_data(1'b0, 64'h8000, 8'd7);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; m_axi_rdata = 64'hBEEF;
        step();
        step();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (w_all_out !== 216'd0) begin
            n_err++;
            $display("FAIL reset_mid_burst: got %h want 0", w_all_out);
        end
        step();
        m_axi_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ic_arvalid = 1'b0; ic_araddr = '0; ic_arlen = '0; ic_arsize = '0; ic_arburst = '0;
        dc_arvalid = 1'b0; dc_araddr = '0; dc_arlen = '0; dc_arsize = '0; dc_arburst = '0;
        ic_rready = 1'b0; dc_rready = 1'b0;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
        snoop_stall = 1'b0;
        @(posedge clk);
        step();
        reset = 1'b0;
        test_reset();
        test_single_ic();
        test_tie_back_to_back();
        test_snoop_stall();
        test_stall_mid_data();
        test_early_rlast();
        test_missing_rlast();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI read master port between the instruction cache (requester IC) and the data cache (requester DC). Grants one full read burst at a time, forwards the AR request and steers R beats back to the owner, and drives the `instruction_cache_reading` / `data_cache_reading` ownership flags. It also holds off new grants while a snoop stall is active and flags burst-length violations. Sits between the two cache instances and the top-level `m_axi_ar*` / `m_axi_r*` pins.

## Interface
- `addr_width`, 64: AR address width.
- `data_width`, 64: R data width.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ic_arvalid`, `dc_arvalid` in 1: burst request valid.
- `ic_araddr`, `dc_araddr` in addr_width: burst address.
- `ic_arlen`, `dc_arlen` in 8: beats minus one.
- `ic_arsize`, `dc_arsize` in 3: beat size.
- `ic_arburst`, `dc_arburst` in 2: burst type.
- `ic_arready`, `dc_arready` out 1: one-cycle request-accepted pulse.
- `ic_rvalid`, `dc_rvalid` out 1: steered R valid.
- `ic_rlast`, `dc_rlast` out 1: steered R last.
- `ic_rdata`, `dc_rdata` out data_width: steered R data.
- `ic_rready`, `dc_rready` in 1: requester accepts a beat.
- `m_axi_arvalid` out 1, `m_axi_araddr` out addr_width, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2: AR channel to the bus.
- `m_axi_arready` in 1: AR channel ready from the bus.
- `m_axi_rvalid` in 1, `m_axi_rlast` in 1, `m_axi_rdata` in data_width: R channel from the bus.
- `m_axi_rready` out 1: R channel ready to the bus.
- `snoop_stall` in 1: blocks new grants.
- `instruction_cache_reading`, `data_cache_reading` out 1: ownership flags.
- `rlast_error` out 1: sticky protocol error.

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - If `snoop_stall` = 0 and either `*_arvalid` is high, select a winner and pulse its `*_arready` combinationally in the same cycle.
  - Capture the winner's addr/len/size/burst into registers and record the owner. Next state: ADDR.
  - With `snoop_stall` = 1, no grant is made and both `*_arready` stay 0.
- **ADDR**
  - `m_axi_arvalid` = 1 and `m_axi_ar*` are driven from the capture registers.
  - On `m_axi_arready`: clear the beat counter. Next state: DATA.
- **DATA**
  - Owner's `rvalid`/`rlast`/`rdata` = `m_axi_r*`. Non-owner's `rvalid`/`rlast` = 0 and `rdata` = 0.
  - `m_axi_rready` = owner's `rready`.
  - The beat counter (9-bit) increments on each `m_axi_rvalid` & `m_axi_rready` beat.
  - On a beat with `rlast` = 1: return to IDLE. If that beat is not number `arlen` (0-based), set `rlast_error`.
  - On a beat with index == `arlen` but `rlast` = 0: set `rlast_error` and stay in DATA until `rlast`.
- Ownership flags: `instruction_cache_reading` = 1 in ADDR/DATA when the owner is IC, 0 otherwise. `data_cache_reading` likewise for DC. They are never both 1.
- `rlast_error` is sticky until `reset`.
- Requesters hold `*_arvalid` and the AR fields stable until they see `*_arready`.
- `snoop_stall` never aborts a grant or burst already in flight.

## Timing
- Reset values: all outputs 0; state IDLE; last-grant register = IC (so DC is preferred next under round-robin).
- Request-to-AR latency:
  - Request in IDLE at cycle N gives `*_arready` = 1 at N.
  - `m_axi_arvalid` = 1 from N+1 until the `m_axi_arready` cycle, inclusive.
- R path is combinational: zero added latency on valid, data and ready.
- The last beat handshake at cycle M puts the FSM in IDLE at M+1. A new grant is possible at M+1, so there is one bubble cycle between bursts.
- Simultaneous IC and DC requests: resolved by the arbitration policy in Configuration.
- A request that appears while the FSM is busy is served in the first IDLE cycle with `snoop_stall` = 0.
- Reset mid-burst: return to IDLE and drop ownership immediately. Bus-side beats still outstanding are not drained, so the interconnect is reset together with this block.

## Configuration
- Macro: `AXI_READ_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin. On a tie, the requester not granted last wins. The last-grant register updates at each grant.
- Undefined: fixed priority, DC always beats IC. The last-grant register is unused. IC can starve under back-to-back DC traffic, which is accepted for that build.

## Test plan
- Single IC request, `araddr` = 0x1000, `arlen` = 7, bus returns 8 beats with `rlast` on beat 7:
  - `ic_arready` pulses once; AR appears the next cycle with `araddr` = 0x1000, `arlen` = 7.
  - IC receives all 8 beats; DC sees `rvalid` = 0 and `rdata` = 0.
  - `instruction_cache_reading` = 1 for the whole burst; `rlast_error` = 0.
- IC and DC request in the same cycle, twice back-to-back:
  - Round-robin build: DC, then IC.
  - Fixed-priority build: DC, then DC again if it re-requests.
  - Reading flags are never both 1.
- `snoop_stall` = 1 with DC requesting for 5 cycles:
  - No `dc_arready` and `m_axi_arvalid` = 0 throughout.
  - After the stall drops: `dc_arready` the same cycle, AR the next cycle.
- `snoop_stall` raised mid-DATA on a DC burst with `arlen` = 3: all 4 beats complete normally, then no new grant is made while the stall stays high.
- Error cases with `arlen` = 3:
  - `rlast` on beat 1: `rlast_error` = 1 and FSM returns to IDLE.
  - No `rlast` on beat 3: `rlast_error` = 1 and the FSM waits for `rlast`.
- `reset` asserted during DATA: next cycle all outputs are 0, state IDLE, `rlast_error` = 0.
